// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM states, word geometry and constants for the data-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int          WORD_BYTES      = 4;
    localparam int          DEFAULT_LATENCY = 2;
    localparam logic [31:0] ZERO_DATA       = 32'h0;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[$clog2(WORD_BYTES)-1:0] != '0;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the CPU memory stage and the data memory.
interface mem_responder_if;

    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: single-port word RAM with synchronous write and registered, held read data.
module mem_responder_ram
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (en && we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata <= ZERO_DATA;
        else if (en) rdata <= rd ? mem[addr] : ZERO_DATA;
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: one-at-a-time load/store responder with fixed LATENCY wait states.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to flag misaligned requests with resp_err instead of ignoring addr[1:0].
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input logic           clk,
    input logic           reset,
    mem_responder_if.slave bus
);

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic                  accept, access, err_in, unused;
    logic                  wr, err, resp_err;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign err_in = misaligned(bus.req_addr);
`else
    assign err_in = 1'b0;
`endif

    // Upper address bits wrap away; the byte offset only matters with the alignment check.
    assign unused = ^{bus.req_addr[31:ADDR_WIDTH+2], bus.req_addr[1:0]};

    assign accept = state == IDLE && bus.req_valid;
    assign access = state == BUSY && cnt == 4'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (accept) begin
            state_next = BUSY;
            cnt_next   = 4'(LATENCY - 1);
        end else if (state == BUSY) begin
            state_next = access ? RESP : BUSY;
            cnt_next   = access ? cnt : cnt - 4'd1;
        end else if (state == RESP) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr    <= 1'b0;
            err   <= 1'b0;
            addr  <= '0;
            wdata <= ZERO_DATA;
        end else if (accept) begin
            wr    <= bus.req_write;
            err   <= err_in;
            addr  <= bus.req_addr[ADDR_WIDTH+1:2];
            wdata <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) resp_err <= 1'b0;
        else if (access) resp_err <= err;
    end

    mem_responder_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (access),
        .we    (wr && !err),
        .rd    (!wr && !err),
        .addr  (addr),
        .wdata (wdata),
        .rdata (bus.resp_rdata)
    );

    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_err   = resp_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench; a reference model tracks acceptance, timing and RAM contents.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int AW    = 8;
    localparam int LAT   = DEFAULT_LATENCY;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic        write;
        int          idx;
        logic [31:0] data;
        logic        err;
        int          t0;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mem_responder_if bus();

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    req_t        q[$];
    logic [31:0] mdl [DEPTH];
    int          edge_n = 0;
    int          free_at = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, required %h", name, edge_n, act, exp);
        end
    endtask

    function automatic logic exp_err(input logic [31:0] a);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        return a % WORD_BYTES != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Accepts a request whenever one is offered and the responder should be free again.
    always @(posedge clk) begin
        if (!reset && bus.req_valid && edge_n >= free_at) begin
            q.push_back('{write: bus.req_write,
                          idx:   int'(bus.req_addr / WORD_BYTES % DEPTH),
                          data:  bus.req_wdata,
                          err:   exp_err(bus.req_addr),
                          t0:    edge_n});
            free_at = edge_n + LAT + 2;
        end
        edge_n++;
    end

    always @(negedge clk) begin
        logic ev;
        req_t r;
        if (!reset) begin
            ev = q.size() > 0 && q[0].t0 + LAT == edge_n - 1;
            check("req_ready", bus.req_ready, edge_n >= free_at);
            check("resp_valid", bus.resp_valid, ev);
            if (ev) begin
                r = q.pop_front();
                check("resp_rdata", bus.resp_rdata, (r.write || r.err) ? 32'h0 : mdl[r.idx]);
                check("resp_err", bus.resp_err, r.err);
                if (r.write && !r.err) mdl[r.idx] = r.data;
            end
        end
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: req_ready=%b, required 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        return ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_err", bus.resp_err, 0);
        reset = 1'b0;
        @(negedge clk);
        // RAM has no reset, so give it a known all-zero image first.
        for (int i = 0; i < DEPTH; i++) send(1'b1, 32'(i * WORD_BYTES), 32'h0);
        send(1'b1, 32'h10, 32'hDEADBEEF);
        send(1'b0, 32'h10, 32'h0);
        send(1'b0, 32'h14, 32'h0);
        send(1'b1, 32'h400, 32'h12345678);
        send(1'b0, 32'h0, 32'h0);
        send(1'b1, 32'h20, 32'h11112222);
        send(1'b1, 32'h22, 32'h55555555);
        send(1'b0, 32'h20, 32'h0);
        // Valid held high with changing payload: only the accepted beats may matter.
        for (int i = 0; i < 12; i++) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'($urandom_range(0, 1));
            bus.req_addr  = rnd_addr();
            bus.req_wdata = $urandom;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 16; i++) send(1'b0, 32'(i * WORD_BYTES), 32'h0);
        send(1'b1, 32'h20, 32'hAAAA5555);
        #2 reset = 1'b1;
        #1;
        check("abort_req_ready", bus.req_ready, 1);
        check("abort_resp_valid", bus.resp_valid, 0);
        check("abort_resp_rdata", bus.resp_rdata, 0);
        check("abort_resp_err", bus.resp_err, 0);
        q.delete();
        free_at = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 200; i++) begin
            send(1'($urandom_range(0, 1)), rnd_addr(), $urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
